// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared gate bus bit positions and checker FSM states
package gate_check_pkg;
    localparam int GATE_W = 7;
    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NAND_B = 2;
    localparam int NOR_B  = 3;
    localparam int NOT_B  = 4;
    localparam int XOR_B  = 5;
    localparam int XNOR_B = 6;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden outputs of the seven gates for one (a,b)
module gate_ref_model
    import gate_check_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expected
);
    // one bit per gate, placed at its gate_bus position
    always_comb begin
        expected         = '0;
        expected[AND_B]  = a & b;
        expected[OR_B]   = a | b;
        expected[NAND_B] = ~(a & b);
        expected[NOR_B]  = ~(a | b);
        expected[NOT_B]  = ~a;
        expected[XOR_B]  = a ^ b;
        expected[XNOR_B] = ~(a ^ b);
    end
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: samples gate responses, compares against golden, keeps run scores
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sample_valid,
    input  logic              a_in,
    input  logic              b_in,
    input  logic [GATE_W-1:0] gate_bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [1:0]        first_fail_ab,
    output logic [GATE_W-1:0] first_fail_mask
);
    // accepted-sample counter sized from the run length, independent of score width
    localparam int ACC_W = $clog2(NUM_VECTORS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_nxt;
    logic [ACC_W-1:0]  acc_cnt;
    logic              s1_valid, s1_a, s1_b;
    logic [GATE_W-1:0] s1_bus, expected, mask;
    logic              accept, launch, last;
    assign accept = (state == RUN) && sample_valid;
    assign launch = start && ((state == IDLE) || (state == DONE));
    assign last   = accept && (acc_cnt == ACC_W'(NUM_VECTORS - 1));
    assign mask   = expected ^ s1_bus;
    gate_ref_model u_ref (
        .a        (s1_a),
        .b        (s1_b),
        .expected (expected)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state: DRAIN covers the single cycle the last sample spends in compare
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (last)  state_nxt = DRAIN;
            DRAIN:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end
    // registered status flags taken from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done <= (state_nxt == DONE);
        end
    end
    // accepted-sample count and stage-1 capture of the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_a     <= 1'b0;
            s1_b     <= 1'b0;
            s1_bus   <= '0;
        end else begin
            s1_valid <= accept;
            if (launch)      acc_cnt <= '0;
            else if (accept) acc_cnt <= acc_cnt + ACC_W'(1);
            if (accept) begin
                s1_a   <= a_in;
                s1_b   <= b_in;
                s1_bus <= gate_bus;
            end
        end
    end
    // stage-2 compare retires into saturating scores; first failure latched once per run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            err             <= 1'b0;
            first_fail_ab   <= '0;
            first_fail_mask <= '0;
        end else if (launch) begin
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            err             <= 1'b0;
            first_fail_ab   <= '0;
            first_fail_mask <= '0;
        end else if (s1_valid) begin
            if (|mask) begin
                fail_cnt <= (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + CNT_W'(1);
                err      <= 1'b1;
                if (!err) begin
                    first_fail_ab   <= {s1_a, s1_b};
                    first_fail_mask <= mask;
                end
            end else begin
                pass_cnt <= (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: three checker configurations driven in parallel against a run-level model
module tb_gate_response_checker;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sample_valid = 1'b0, a_in = 1'b0, b_in = 1'b0;
    logic [6:0] gate_bus = '0;
    logic [2:0] busy, done, err;
    logic [2:0][1:0] ffab;
    logic [2:0][6:0] ffmask;
    logic [7:0] p0, f0;
    logic [1:0] p1, f1;
    logic [0:0] p2, f2;
    int checks = 0, errors = 0;
    int n[3] = '{4, 3, 3};
    int w[3] = '{8, 2, 1};
    int m_acc[3], m_pass[3], m_fail[3], m_ab[3], m_mask[3];
    bit m_run[3], m_drain[3], m_done[3], m_err[3];

    always #5 clk = ~clk;

    gate_response_checker #(.CNT_W(8), .NUM_VECTORS(4)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
        .sample_valid(sample_valid), .a_in(a_in), .b_in(b_in), .gate_bus(gate_bus), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .pass_cnt(p0), .fail_cnt(f0), .first_fail_ab(ffab[0]),
        .first_fail_mask(ffmask[0]));
    gate_response_checker #(.CNT_W(2), .NUM_VECTORS(3)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
        .sample_valid(sample_valid), .a_in(a_in), .b_in(b_in), .gate_bus(gate_bus), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .pass_cnt(p1), .fail_cnt(f1), .first_fail_ab(ffab[1]),
        .first_fail_mask(ffmask[1]));
    gate_response_checker #(.CNT_W(1), .NUM_VECTORS(3)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
        .sample_valid(sample_valid), .a_in(a_in), .b_in(b_in), .gate_bus(gate_bus), .busy(busy[2]),
        .done(done[2]), .err(err[2]), .pass_cnt(p2), .fail_cnt(f2), .first_fail_ab(ffab[2]),
        .first_fail_mask(ffmask[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // truth-table golden from integer arithmetic, ordered and,or,nand,nor,not,xor,xnor
    function automatic logic [6:0] golden(input bit a, input bit b);
        int x = a, y = b;
        logic [6:0] g;
        g[0] = (x * y == 1);
        g[1] = (x + y > 0);
        g[2] = (x * y == 0);
        g[3] = (x + y == 0);
        g[4] = (x == 0);
        g[5] = (x + y == 1);
        g[6] = (x == y);
        return g;
    endfunction

    task automatic model_clear(input int i);
        m_acc[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_ab[i] = 0; m_mask[i] = 0; m_err[i] = 0;
        m_done[i] = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input bit a, input bit b, input logic [6:0] bus);
        for (int i = 0; i < 3; i++) begin
            bit was_drain = m_drain[i];
            int cap = (1 << w[i]) - 1;
            int mk;
            if (s && !m_run[i] && !m_drain[i]) begin
                model_clear(i);
                m_run[i] = 1;
            end else if (v && m_run[i]) begin
                mk = int'(golden(a, b) ^ bus);
                if (mk != 0) begin
                    if (!m_err[i]) begin
                        m_ab[i] = a * 2 + b;
                        m_mask[i] = mk;
                    end
                    m_err[i] = 1;
                    if (m_fail[i] < cap) m_fail[i]++;
                end else if (m_pass[i] < cap) m_pass[i]++;
                m_acc[i]++;
                if (m_acc[i] == n[i]) begin
                    m_run[i] = 0;
                    m_drain[i] = 1;
                end
            end
            if (was_drain) begin
                m_drain[i] = 0;
                m_done[i] = 1;
            end
        end
    endtask

    task automatic step(input bit s, input bit v, input bit a, input bit b, input logic [6:0] bus);
        @(negedge clk);
        start = s; sample_valid = v; a_in = a; b_in = b; gate_bus = bus;
        @(posedge clk);
        model_edge(s, v, a, b, bus);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_run[i] | m_drain[i]));
            chk($sformatf("done%0d", i), int'(done[i]), int'(m_done[i]));
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(0, 0, 0, 0, '0);
    endtask

    task automatic vec(input bit [1:0] ab, input logic [6:0] flip);
        step(0, 1, ab[1], ab[0], golden(ab[1], ab[0]) ^ flip);
    endtask

    task automatic check_all();
        int pc[3], fc[3];
        pc = '{int'(p0), int'(p1), int'(p2)};
        fc = '{int'(f0), int'(f1), int'(f2)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pass_cnt%0d", i), pc[i], m_pass[i]);
            chk($sformatf("fail_cnt%0d", i), fc[i], m_fail[i]);
            chk($sformatf("err%0d", i), int'(err[i]), int'(m_err[i]));
            chk($sformatf("ff_ab%0d", i), int'(ffab[i]), m_ab[i]);
            chk($sformatf("ff_mask%0d", i), int'(ffmask[i]), m_mask[i]);
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_run[i] | m_drain[i]));
            chk($sformatf("done%0d", i), int'(done[i]), int'(m_done[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            model_clear(i);
            m_run[i] = 0; m_drain[i] = 0;
        end
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        vec(2'b00, '0); vec(2'b11, 7'h7f);
        check_all();
        step(1, 0, 0, 0, '0);
        vec(2'b00, '0); vec(2'b01, '0); vec(2'b10, '0); vec(2'b11, '0);
        idle(2);
        check_all();
        chk("gold00", int'(golden(0, 0)), 'b1011100);
        step(1, 0, 0, 0, '0);
        vec(2'b00, '0); vec(2'b01, '0); vec(2'b10, 7'b0100000); vec(2'b11, '0);
        idle(2);
        check_all();
        step(1, 0, 0, 0, '0);
        vec(2'b00, '0); vec(2'b01, 7'b0000001); vec(2'b10, '0); vec(2'b11, 7'b1000010);
        idle(2);
        check_all();
        vec(2'b10, 7'b0010000); vec(2'b01, '0);
        idle(1);
        check_all();
        step(1, 1, 1, 1, '0);
        vec(2'b01, 7'b0001000);
        step(1, 1, 0, 0, golden(0, 0));
        vec(2'b10, '0); vec(2'b11, '0);
        idle(2);
        check_all();
        step(1, 0, 0, 0, '0);
        vec(2'b01, 7'b0000100); vec(2'b10, '0);
        do_reset();
        step(1, 0, 0, 0, '0);
        vec(2'b00, '0); vec(2'b01, '0); vec(2'b10, '0); vec(2'b11, '0);
        idle(2);
        check_all();
        for (int r = 0; r < 30; r++) begin
            step(1, $urandom % 2 == 0, 0, 0, '0);
            for (int c = 0; c < 10; c++) begin
                bit a = $urandom % 2, b = $urandom % 2;
                logic [6:0] flip = ($urandom % 4 == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
                step($urandom % 8 == 0, $urandom % 4 != 0, a, b, golden(a, b) ^ flip);
            end
            idle(2);
            check_all();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
